// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (with helper ripple_carry_adder)
// Brief    : Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry
//            slice, one nibble per clock, LSB first, with the carry held in a
//            register between slices. Valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================

// 4-bit ripple-carry adder slice: {co,s} = a + b + ci
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] w_c;

    assign w_c[0] = ci;

    // One full adder per bit, carry rippling upward.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = w_c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] c_last = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;

    logic [3:0]        w_slice_a;
    logic [3:0]        w_slice_b;
    logic [3:0]        w_slice_sum;
    logic              w_slice_co;

    // Current nibble of each latched operand feeds the shared slice.
    assign w_slice_a = r_a[4*r_idx +: 4];
    assign w_slice_b = r_b[4*r_idx +: 4];

    ripple_carry_adder u_slice (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .ci (r_carry),
        .s  (w_slice_sum),
        .co (w_slice_co)
    );

    // Handshake flags are pure state decodes, so no input reaches an output
    // combinationally and the two flags can never be high together.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    // Sequencer: accept operands, walk the slices LSB first, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_slice_sum;
                    r_carry             <= w_slice_co;
                    if (r_idx == c_last) begin
                        r_cout  <= w_slice_co;
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Self-checking bench for nibble_serial_adder (WIDTH=16 and 4).
//            Expected results are queued at issue time and compared by an
//            independent monitor at each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
    logic [3:0]  a4, b4, sum4;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: at every output handshake pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {15'd0, cout, sum}, 32'hDEAD_BEEF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("result", {15'd0, cout, sum}, {15'd0, e});
            end
        end
    end

    // Issue one operation on the 16-bit DUT; optionally queue its expectation.
    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input bit push);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        a = xa; b = xb; cin = xc;
        if (push) exp_q.push_back({1'b0, xa} + {1'b0, xb} + {16'd0, xc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    // Wait (bounded) until out_valid is seen at a falling edge.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!out_valid && cycles < 50) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] hs;
        logic        hc;

        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
        in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_sum", {16'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: 0x1234 + 0x4321, with latency check.
        send(16'h1234, 16'h4321, 1'b0, 1'b1);
        wait_valid(lat);
        check("latency_w16", lat, 32'd4);
        check("excl_ready_valid", {31'd0, in_ready}, 32'd0);

        // Directed: 0xFFFF + 1, carry register stays 1 after every slice.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("carry_reg_slice", {31'd0, dut.r_carry}, 32'd1);
        end

        // Directed corner cases for cin.
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result held for 6 cycles, in_valid pulses ignored.
        #1;
        wait (exp_q.size() == 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'hA5A5, 16'h1234, 1'b1, 1'b1);
        wait_valid(lat);
        hs = sum; hc = cout;
        for (int k = 0; k < 6; k++) begin
            in_valid = k[0];
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum_stable", {16'd0, sum}, {16'd0, hs});
            check("bp_cout_stable", {31'd0, cout}, {31'd0, hc});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset during RUN: partial result discarded.
        send(16'hABCD, 16'h1111, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_sum", {16'd0, sum}, 32'd0);
        check("async_rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b1);

        // WIDTH=4 instance: result one cycle after accept.
        @(negedge clk);
        in_valid4 = 1'b1; a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        @(negedge clk);
        check("w4_not_yet_valid", {31'd0, out_valid4}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("w4_out_valid", {31'd0, out_valid4}, 32'd1);
        check("w4_sum", {28'd0, sum4}, 32'h2);
        check("w4_cout", {31'd0, cout4}, 32'd1);

        // Random back-to-back traffic.
        for (int n = 0; n < 1000; n++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        end

        lat = 0;
        while (exp_q.size() != 0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
